// File: rtl/alu_arbiter_pkg.sv
// Shared types and defaults for the two-requester ALU arbiter.
// Holds the FSM state encoding, the requester id type and the default bus widths.
package alu_arbiter_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of both requester channels plus the shared ALU hookup.
// master = requesters and external ALU, slave = arbiter.
interface alu_arbiter_if #(
  parameter int DATA_W = alu_arbiter_pkg::DEFAULT_DATA_W,
  parameter int SEL_W  = alu_arbiter_pkg::DEFAULT_SEL_W
);

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [SEL_W-1:0]  req0_s;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [SEL_W-1:0]  req1_s;

  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [DATA_W-1:0] rsp0_data;

  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp1_data;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [SEL_W-1:0]  alu_s;
  logic [DATA_W-1:0] alu_out;

  modport master (
    output req0_valid, req0_a, req0_b, req0_s,
    output req1_valid, req1_a, req1_b, req1_s,
    output rsp0_ready, rsp1_ready,
    output alu_out,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    input  alu_a, alu_b, alu_s
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_s,
    input  req1_valid, req1_a, req1_b, req1_s,
    input  rsp0_ready, rsp1_ready,
    input  alu_out,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    output alu_a, alu_b, alu_s
  );

endinterface

// File: rtl/alu_arb_pick.sv
// Two-way grant picker. Round-robin on last_grant by default;
// ALU_ARB_FIXED_PRIO_EN makes requester 0 always win and ignores last_grant.
module alu_arb_pick
  import alu_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  req_id_t    last_grant,
  output req_id_t    grant,
  output logic       grant_valid
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant_valid = |valid;
    grant       = 1'b0;
    if (!valid[0])
      grant = 1'b1;
  end
`else
  // Under contention the requester not served last time wins.
  always_comb begin
    grant_valid = |valid;
    grant       = 1'b0;
    if (valid == 2'b11)
      grant = ~last_grant;
    else if (valid[1])
      grant = 1'b1;
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two valid/ready requesters.
// Build option: ALU_ARB_FIXED_PRIO_EN selects fixed priority (requester 0) instead of round-robin.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int SEL_W  = DEFAULT_SEL_W
)
(
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  state_t            state;
  req_id_t           owner;
  req_id_t           last_grant;
  req_id_t           grant;
  logic              grant_valid;
  logic [1:0]        req_valid;
  logic              idle;
  logic              req_fire;
  logic              rsp_fire;
  logic              rsp0_valid_q;
  logic              rsp1_valid_q;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [SEL_W-1:0]  op_s;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [SEL_W-1:0]  sel_s;

  assign req_valid = {bus.req1_valid, bus.req0_valid};

  alu_arb_pick u_pick (
    .valid       (req_valid),
    .last_grant  (last_grant),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign last_grant = 1'b1;
`endif

  // Ready only ever looks at state and request valids, never at any rsp_ready.
  assign idle           = (state == IDLE) && !rst;
  assign bus.req0_ready = idle && grant_valid && (grant == 1'b0);
  assign bus.req1_ready = idle && grant_valid && (grant == 1'b1);
  assign req_fire       = idle && grant_valid;

  assign sel_a = grant ? bus.req1_a : bus.req0_a;
  assign sel_b = grant ? bus.req1_b : bus.req0_b;
  assign sel_s = grant ? bus.req1_s : bus.req0_s;

  assign rsp_fire = owner ? (rsp1_valid_q && bus.rsp1_ready)
                          : (rsp0_valid_q && bus.rsp0_ready);

  assign bus.alu_a = op_a;
  assign bus.alu_b = op_b;
  assign bus.alu_s = op_s;

  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp0_data  = rsp0_valid_q ? result : '0;
  assign bus.rsp1_data  = rsp1_valid_q ? result : '0;

  // Accept in IDLE, sample the ALU in EXEC, hold the result in RESP until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= 1'b0;
      op_a         <= '0;
      op_b         <= '0;
      op_s         <= '0;
      result       <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant   <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_fire) begin
            op_a  <= sel_a;
            op_b  <= sel_b;
            op_s  <= sel_s;
            owner <= grant;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant <= grant;
`endif
            state <= EXEC;
          end
        end
        EXEC: begin
          result <= bus.alu_out;
          if (owner)
            rsp1_valid_q <= 1'b1;
          else
            rsp0_valid_q <= 1'b1;
          state <= RESP;
        end
        RESP: begin
          if (rsp_fire) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
